// File: rtl/truss_pkg.sv
// Shared definitions for the timeout handler: state encoding, parameter defaults, saturating counter helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package truss_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_REQUEST = 2'd1,
        ST_DONE    = 2'd2,
        ST_HUNG    = 2'd3
    } state_e;

    localparam int DEFAULT_GRACE_CYCLES = 100;
    localparam int DEFAULT_GRACE_WIDTH  = 16;
    localparam int DEFAULT_SYNC_STAGES  = 2;
    localparam int COUNT_WIDTH          = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/truss_sync_edge.sv
// Synchronizes an asynchronous level into clk and flags its rising edge.
// Latency: sync_o follows async_i after SYNC_STAGES edges; rise_o is combinational from registered state.
// Backpressure: none; rise_o is a one-cycle pulse per low-to-high transition of sync_o.
//   Ports: clk, reset (async active-high), async_i (raw level), sync_o (synchronized level), rise_o (edge pulse)
module truss_sync_edge
    import truss_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES  // must be >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    // Decoded from flops only, so the pulse is glitch-free relative to async_i.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/timeout_handler.sv
// Turns a watchdog expiry into a shutdown request with a bounded grace window, then DONE or a sticky HUNG.
// Latency: shutdown_req rises SYNC_STAGES+1 edges after timeout; stays high at most GRACE_CYCLES+1 cycles.
// Backpressure: none; events arriving outside ARMED are dropped, rearm is refused while timeout is still high.
//   Ports: clk, reset (async active-high), timeout (async level), shutdown_ack, rearm (pulse),
//          shutdown_req / shutdown_done / hung (state decodes), timeout_count (saturating event count)
module timeout_handler
    import truss_pkg::*;
#(
    parameter int GRACE_CYCLES = DEFAULT_GRACE_CYCLES,
    parameter int GRACE_WIDTH  = DEFAULT_GRACE_WIDTH,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   timeout,
    input  logic                   shutdown_ack,
    input  logic                   rearm,
    output logic                   shutdown_req,
    output logic                   shutdown_done,
    output logic                   hung,
    output logic [COUNT_WIDTH-1:0] timeout_count
);

    state_e                  state_q, state_d;
    logic [GRACE_WIDTH-1:0]  grace_q, grace_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    tmo_sync;
    logic                    tmo_rise;

    truss_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .async_i (timeout),
        .sync_o  (tmo_sync),
        .rise_o  (tmo_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARMED;
            grace_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grace_q <= grace_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        count_d = count_q;
        case (state_q)
            ST_ARMED: begin
                if (tmo_rise) begin
                    state_d = ST_REQUEST;
                    grace_d = GRACE_WIDTH'(GRACE_CYCLES);
                    count_d = sat_inc(count_q);
                end
            end
            ST_REQUEST: begin
                // Ack is checked first so an ack on the last grace cycle still completes cleanly.
                if (shutdown_ack) begin
                    state_d = ST_DONE;
                end else if (grace_q == '0) begin
                    state_d = ST_HUNG;
                end else begin
                    grace_d = grace_q - GRACE_WIDTH'(1);
                end
            end
            ST_DONE: begin
                // Re-arming while the watchdog is still asserted would miss its next edge.
                if (rearm && !tmo_sync) begin
                    state_d = ST_ARMED;
                end
            end
            ST_HUNG: begin
                state_d = ST_HUNG;
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    assign shutdown_req  = (state_q == ST_REQUEST);
    assign shutdown_done = (state_q == ST_DONE);
    assign hung          = (state_q == ST_HUNG);
    assign timeout_count = count_q;

endmodule

// File: tb/tb_timeout_handler.sv
module tb_timeout_handler;
    import truss_pkg::*;

    localparam int G = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       timeout = 1'b0;
    logic       shutdown_ack = 1'b0;
    logic       rearm = 1'b0;
    logic       shutdown_req, shutdown_done, hung;
    logic [7:0] timeout_count;
    logic       g0_req, g0_done, g0_hung;
    logic [7:0] g0_count;

    int checks = 0;
    int failures = 0;
    int m_count = 0;   // model: accepted events, saturating at 255

    timeout_handler #(.GRACE_CYCLES(G), .GRACE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .timeout(timeout), .shutdown_ack(shutdown_ack), .rearm(rearm),
        .shutdown_req(shutdown_req), .shutdown_done(shutdown_done), .hung(hung),
        .timeout_count(timeout_count)
    );

    timeout_handler #(.GRACE_CYCLES(0), .GRACE_WIDTH(16), .SYNC_STAGES(2)) dut_g0 (
        .clk(clk), .reset(reset), .timeout(timeout), .shutdown_ack(shutdown_ack), .rearm(rearm),
        .shutdown_req(g0_req), .shutdown_done(g0_done), .hung(g0_hung),
        .timeout_count(g0_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_event;
        if (m_count < 255) m_count = m_count + 1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_count = 0;
    endtask

    // Raise timeout and wait the three edges needed to reach the request.
    task automatic raise_timeout;
        timeout = 1'b1;
        tick(); tick(); tick();
        model_event();
    endtask

    // Holds the request, acking on request cycle ack_cycle (0 = never); reports cycles seen high.
    task automatic measure_req(input int ack_cycle, output int len);
        len = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (!shutdown_req) break;
            len++;
            shutdown_ack = (cyc == ack_cycle);
            tick();
        end
        shutdown_ack = 1'b0;
    endtask

    task automatic return_to_armed;
        timeout = 1'b0;
        tick(); tick(); tick();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
    endtask

    task automatic test_reset;
        timeout = 1'b0; shutdown_ack = 1'b0; rearm = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (shutdown_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", shutdown_req); end
        checks++; if (shutdown_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", shutdown_done); end
        checks++; if (hung !== 1'b0) begin failures++; $display("FAIL reset_hung got=%b exp=0", hung); end
        checks++; if (timeout_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", timeout_count); end
        tick();
        reset = 1'b0;
        m_count = 0;
        tick();
    endtask

    task automatic test_latency_ack10;
        int len;
        timeout = 1'b1;
        tick(); tick();
        checks++; if (shutdown_req !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", shutdown_req); end
        tick();
        model_event();
        checks++; if (shutdown_req !== 1'b1) begin failures++; $display("FAIL lat_edge3 got=%b exp=1", shutdown_req); end
        checks++; if (g0_req !== 1'b1) begin failures++; $display("FAIL g0_req got=%b exp=1", g0_req); end
        measure_req(10, len);
        checks++; if (len !== 10) begin failures++; $display("FAIL ack10_len got=%0d exp=10", len); end
        checks++; if (shutdown_done !== 1'b1) begin failures++; $display("FAIL ack10_done got=%b exp=1", shutdown_done); end
        checks++; if (timeout_count !== 8'(m_count)) begin failures++; $display("FAIL ack10_count got=%0d exp=%0d", timeout_count, m_count); end
        // Zero-grace instance: exactly one request cycle, then hung.
        checks++; if (g0_hung !== 1'b1 || g0_req !== 1'b0) begin failures++; $display("FAIL g0_hung hung=%b req=%b exp=1/0", g0_hung, g0_req); end
    endtask

    task automatic test_rearm;
        int len;
        // timeout still high from the previous event: rearm must be ignored
        rearm = 1'b1; tick(); rearm = 1'b0; tick();
        checks++; if (shutdown_done !== 1'b1) begin failures++; $display("FAIL rearm_high got=%b exp=1", shutdown_done); end
        shutdown_ack = 1'b1; tick(); shutdown_ack = 1'b0;
        checks++; if (shutdown_done !== 1'b1 || shutdown_req !== 1'b0) begin failures++; $display("FAIL ack_in_done done=%b req=%b exp=1/0", shutdown_done, shutdown_req); end
        return_to_armed();
        checks++; if (shutdown_done !== 1'b0 || shutdown_req !== 1'b0) begin failures++; $display("FAIL rearm_low done=%b req=%b exp=0/0", shutdown_done, shutdown_req); end
        // ack / rearm in ARMED have no effect
        shutdown_ack = 1'b1; rearm = 1'b1; tick(); tick(); shutdown_ack = 1'b0; rearm = 1'b0;
        checks++; if ({shutdown_req, shutdown_done, hung} !== 3'b000) begin failures++; $display("FAIL armed_ignore got=%b exp=000", {shutdown_req, shutdown_done, hung}); end
        raise_timeout();
        measure_req(int'($urandom_range(1, G + 1)), len);
        checks++; if (timeout_count !== 8'(m_count) || m_count != 2) begin failures++; $display("FAIL second_count got=%0d exp=2", timeout_count); end
        checks++; if (shutdown_done !== 1'b1) begin failures++; $display("FAIL second_done got=%b exp=1", shutdown_done); end
        return_to_armed();
    endtask

    task automatic test_ack_at_zero;
        int len;
        raise_timeout();
        measure_req(G + 1, len);
        checks++; if (len !== G + 1) begin failures++; $display("FAIL zero_len got=%0d exp=%0d", len, G + 1); end
        checks++; if (shutdown_done !== 1'b1 || hung !== 1'b0) begin failures++; $display("FAIL zero_win done=%b hung=%b exp=1/0", shutdown_done, hung); end
        return_to_armed();
    endtask

    task automatic test_random;
        int ack, len, exp_len;
        bit exp_hung;
        for (int i = 0; i < 16; i++) begin
            ack = ($urandom_range(0, 3) == 0) ? G + 1 : int'($urandom_range(1, G + 2));
            exp_hung = (ack > G + 1);
            exp_len = exp_hung ? G + 1 : ack;
            raise_timeout();
            measure_req(ack, len);
            checks++; if (len !== exp_len) begin failures++; $display("FAIL rnd_len i=%0d ack=%0d got=%0d exp=%0d", i, ack, len, exp_len); end
            checks++; if (hung !== exp_hung || shutdown_done !== !exp_hung) begin failures++; $display("FAIL rnd_end i=%0d hung=%b done=%b exp_hung=%b", i, hung, shutdown_done, exp_hung); end
            checks++; if (timeout_count !== 8'(m_count)) begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, timeout_count, m_count); end
            if (exp_hung) begin
                timeout = 1'b0;
                do_reset();
                tick(); tick();
            end else begin
                return_to_armed();
            end
        end
    endtask

    task automatic test_hung;
        int len;
        do_reset();
        raise_timeout();
        measure_req(0, len);
        checks++; if (len !== G + 1) begin failures++; $display("FAIL hung_len got=%0d exp=%0d", len, G + 1); end
        checks++; if (hung !== 1'b1) begin failures++; $display("FAIL hung_set got=%b exp=1", hung); end
        shutdown_ack = 1'b1; rearm = 1'b1; tick(); shutdown_ack = 1'b0; rearm = 1'b0;
        return_to_armed();
        raise_timeout();
        m_count = 1;  // event not accepted while hung
        tick(); tick();
        checks++; if ({shutdown_req, shutdown_done, hung} !== 3'b001) begin failures++; $display("FAIL hung_sticky got=%b exp=001", {shutdown_req, shutdown_done, hung}); end
        checks++; if (timeout_count !== 8'(m_count)) begin failures++; $display("FAIL hung_count got=%0d exp=%0d", timeout_count, m_count); end
    endtask

    task automatic test_reset_mid_request;
        do_reset();
        raise_timeout();
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        checks++; if ({shutdown_req, shutdown_done, hung} !== 3'b000 || timeout_count !== 8'd0) begin failures++; $display("FAIL midreset_clear got=%b cnt=%0d exp=000/0", {shutdown_req, shutdown_done, hung}, timeout_count); end
        tick();
        reset = 1'b0;
        m_count = 0;
        tick(); tick();
        checks++; if (shutdown_req !== 1'b0) begin failures++; $display("FAIL midreset_early got=%b exp=0", shutdown_req); end
        tick();
        model_event();
        checks++; if (shutdown_req !== 1'b1) begin failures++; $display("FAIL midreset_req got=%b exp=1", shutdown_req); end
        checks++; if (timeout_count !== 8'(m_count)) begin failures++; $display("FAIL midreset_count got=%0d exp=%0d", timeout_count, m_count); end
    endtask

    task automatic test_saturation;
        int len;
        timeout = 1'b0;
        do_reset();
        tick(); tick();
        for (int i = 0; i < 300; i++) begin
            raise_timeout();
            measure_req(1, len);
            checks++; if (timeout_count !== 8'(m_count)) begin failures++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, timeout_count, m_count); end
            return_to_armed();
        end
        checks++; if (timeout_count !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", timeout_count); end
    endtask

    initial begin
        test_reset();
        test_latency_ack10();
        test_rearm();
        test_ack_at_zero();
        test_random();
        test_hung();
        test_reset_mid_request();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timeout_handler.md
TIMEOUT_HANDLER -- requirements
Module: timeout_handler

Interface
REQ-001 The block SHALL take parameter GRACE_CYCLES, default 100, as the number of cycles the test environment has to acknowledge a shutdown request.
REQ-002 The block SHALL take parameter GRACE_WIDTH, default 16, as the width of the grace counter; GRACE_CYCLES SHALL fit in GRACE_WIDTH bits.
REQ-003 The block SHALL take parameter SYNC_STAGES, default 2 (minimum 2), as the depth of the timeout synchronizer.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port timeout, input, 1 bit: watchdog expiry level, asynchronous to clk.
REQ-007 The block SHALL have port shutdown_ack, input, 1 bit: test environment acknowledges the shutdown request.
REQ-008 The block SHALL have port rearm, input, 1 bit: single-cycle pulse that returns the block from DONE to ARMED.
REQ-009 The block SHALL have port shutdown_req, output, 1 bit: high while in REQUEST.
REQ-010 The block SHALL have port shutdown_done, output, 1 bit: high while in DONE.
REQ-011 The block SHALL have port hung, output, 1 bit: sticky; high while in HUNG.
REQ-012 The block SHALL have port timeout_count, output, 8 bits: saturating count of accepted timeout events.

Function
REQ-013 timeout SHALL pass through a SYNC_STAGES flop chain; a rising edge SHALL be detected as sync_out high while its previous-cycle value was low.
REQ-014 The state machine SHALL have four states: ARMED, REQUEST, DONE, HUNG; all outputs SHALL be registered or decoded from registered state only.
REQ-015 ARMED -> REQUEST on a detected rising edge; shutdown_req SHALL go high SYNC_STAGES+1 rising clk edges after timeout first meets setup.
REQ-016 On entry to REQUEST the grace counter SHALL load GRACE_CYCLES, and timeout_count SHALL increment, saturating at 255.
REQ-017 In REQUEST, shutdown_ack=1 -> DONE; otherwise, if the counter is 0 -> HUNG; otherwise the counter decrements by 1.
REQ-018 A shutdown_ack in the same cycle the counter reaches 0 SHALL win, giving DONE, not HUNG.
REQ-019 shutdown_req SHALL be high for at most GRACE_CYCLES+1 cycles; GRACE_CYCLES=0 SHALL give exactly one request cycle.
REQ-020 DONE -> ARMED only when rearm=1 and the synchronized timeout is low; rearm while the synchronized timeout is high SHALL be ignored.
REQ-021 HUNG SHALL be terminal until reset; rearm and shutdown_ack SHALL be ignored there.
REQ-022 shutdown_ack in ARMED, DONE or HUNG, and rearm outside DONE, SHALL have no effect.
REQ-023 A timeout level held high SHALL cause only one event; a new event requires low then high at the synchronizer output.

Reset
REQ-024 Asserting reset SHALL immediately set: state ARMED; shutdown_req=0; shutdown_done=0; hung=0; timeout_count=0; grace counter=0; synchronizer and edge flops=0.
REQ-025 Reset asserted mid-REQUEST SHALL drop shutdown_req asynchronously; after release, a still-high timeout SHALL be detected as a new event.

Structure
REQ-026 The state encoding enum and the default GRACE_CYCLES/SYNC_STAGES values SHALL live in a shared truss package.
REQ-027 The synchronizer-plus-edge-detector SHALL be one sub-module, truss_sync_edge, parameterized by SYNC_STAGES.

Verification
REQ-028 Scenario: timeout rises at t0; ack after 10 request cycles -> shutdown_req high 3 edges after t0, for 10 cycles; shutdown_done=1; timeout_count=1.
REQ-029 Scenario: timeout rises, no ack, GRACE_CYCLES=100 -> shutdown_req high 101 cycles, then hung=1 sticky; later ack/rearm have no effect.
REQ-030 Scenario: ack asserted in the cycle the counter is 0 -> DONE, hung stays 0.
REQ-031 Scenario: in DONE, rearm with timeout high -> stays DONE; timeout low, then rearm -> ARMED; second timeout -> timeout_count=2.
REQ-032 Scenario: reset pulse mid-REQUEST, timeout held high -> outputs cleared at once; after release a new request starts 3 edges later, timeout_count=1.
REQ-033 Scenario: 300 timeout/ack/rearm cycles -> timeout_count saturates at 255.
